game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter MAX_ROUNDS, 16, rounds needed to win (>=1).
REQ-002 Parameter ROUND_W, 5, round counter width (2^ROUND_W > MAX_ROUNDS).
REQ-003 Parameter TIMEOUT_CYC, 50000000, user-phase inactivity timeout in clock cycles (>=2).
REQ-004 Parameter TIMER_W, 26, timeout counter width (2^TIMER_W >= TIMEOUT_CYC).
REQ-005 Parameter LIVES, 3, lives per game (>=1; used only with GAME_CTRL_LIVES_EN).
REQ-006 clock  in  1  sole clock; all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enter  in  1  start/acknowledge button, level; block edge-detects internally.
REQ-009 end_fpga  in  1  sequence playback finished.
REQ-010 end_user  in  1  user finished entering sequence.
REQ-011 match  in  1  user sequence matched, valid in CHECK.
REQ-012 user_act  in  1  any user key press; restarts timeout.
REQ-013 r1, r2  out  1 each  datapath resets (r1 full, r2 round-local).
REQ-014 e1, e2, e3, e4  out  1 each  enables: setup, user, FPGA playback, compare.
REQ-015 sel  out  1  display mux selects result.
REQ-016 round  out  ROUND_W  completed-round count.
REQ-017 win  out  1  registered, game won.
REQ-018 timeout  out  1  registered, game ended by timeout.
REQ-019 lives_left  out  ROUND_W  remaining lives (constant 1 when macro absent).

Function
REQ-020 States: INIT, SETUP, PLAY_FPGA, PLAY_USER, CHECK, NEXT_ROUND, RESULT; RETRY added with macro.
REQ-021 Outputs r1..sel are Moore, decoded from state register only, all 0 unless listed: INIT r1=r2=1; SETUP e1; PLAY_FPGA e3; PLAY_USER e2; CHECK e4; NEXT_ROUND r2; RESULT sel; RETRY r2.
REQ-022 enter_rise = enter & ~enter_q (enter_q registered); only enter_rise causes transitions, so held enter advances at most one state.
REQ-023 INIT -> SETUP unconditionally after 1 cycle; INIT clears round, win, timeout, timer; loads lives_left=LIVES.
REQ-024 SETUP -> PLAY_FPGA on enter_rise.
REQ-025 PLAY_FPGA -> PLAY_USER when end_fpga=1; timer cleared on this transition.
REQ-026 PLAY_USER: timer increments each cycle; user_act=1 clears timer to 0 that cycle.
REQ-027 Expiry = timer==TIMEOUT_CYC-1 with user_act=0; expiry sets timeout and -> RESULT (or RETRY, REQ-036).
REQ-028 Expiry and end_user in same cycle: expiry wins.
REQ-029 PLAY_USER -> CHECK when end_user=1 and no expiry.
REQ-030 CHECK: match=1 -> NEXT_ROUND; match=0 -> RESULT (or RETRY, REQ-036).
REQ-031 NEXT_ROUND: round <= round+1; if round+1==MAX_ROUNDS set win, -> RESULT; else -> PLAY_FPGA.
REQ-032 round saturates at MAX_ROUNDS; never wraps.
REQ-033 RESULT holds (win/timeout/round stable) until enter_rise, then -> INIT.
REQ-034 Undefined state encodings -> INIT next cycle.

Reset
REQ-035 reset=1 at a clock edge, in any state mid-game: state=INIT, round=0, win=0, timeout=0, timer=0, enter_q=0, lives_left=LIVES; outputs take INIT values (r1=r2=1, rest 0) the following cycle.

Configuration
REQ-036 Macro GAME_CTRL_LIVES_EN defined: mismatch or expiry with lives_left>1 decrements lives_left, clears timeout flag and timer, -> RETRY (1 cycle) -> PLAY_FPGA replaying same round (round unchanged); lives_left==1 -> RESULT as normal.
REQ-037 Macro absent: no RETRY state, no lives register; lives_left tied to 1; mismatch/expiry always -> RESULT.

Structure
REQ-038 Package game_ctrl_pkg holds state encoding constants (3-bit state type) and output-vector bit positions.
REQ-039 Sub-module game_timer (TIMER_W, TIMEOUT_CYC; clear, run, restart inputs; expire output) implements REQ-026/027.

Verification (MAX_ROUNDS=3, TIMEOUT_CYC=8, LIVES=2)
REQ-040 Reset, enter pulse, 3 rounds all match=1 -> round=3, win=1, state RESULT with sel=1; enter pulse -> INIT with r1=r2=1.
REQ-041 Round 2, no user_act/end_user for 8 cycles in PLAY_USER -> timeout=1, RESULT, round=1 (macro absent).
REQ-042 Same cycle expiry and end_user=1 -> RESULT with timeout=1, CHECK never entered.
REQ-043 Macro defined, round 1 match=0 -> RETRY, lives_left=1, round=0, back to PLAY_FPGA; second match=0 -> RESULT, win=0.
REQ-044 enter held high 20 cycles from reset -> state stops in PLAY_FPGA, not re-entering SETUP; reset asserted in PLAY_USER with round=2 -> next cycle INIT, round=0.

Source files
------------

// File: rtl/game_controller_pkg.sv
// Shared state encoding and Moore output bit positions for game_controller.
// Latency: n/a (types only). Backpressure: n/a.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_SETUP      = 3'd1,
    S_PLAY_FPGA  = 3'd2,
    S_PLAY_USER  = 3'd3,
    S_CHECK      = 3'd4,
    S_NEXT_ROUND = 3'd5,
    S_RESULT     = 3'd6,
    S_RETRY      = 3'd7
  } state_t;

  localparam int OUT_W = 7;
  localparam int O_R1  = 6;
  localparam int O_R2  = 5;
  localparam int O_E1  = 4;
  localparam int O_E2  = 3;
  localparam int O_E3  = 2;
  localparam int O_E4  = 1;
  localparam int O_SEL = 0;

endpackage

// File: rtl/game_controller_timer.sv
// User-phase inactivity timer; expire is combinational off the count register.
// Latency: expire asserts in the TIMEOUT_CYC-th idle run cycle. Backpressure: none.
module game_timer #(
  parameter int TIMER_W     = 26,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  input  logic restart,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYC - 1);

  logic [TIMER_W-1:0] count;

  // A key press in the same cycle as the terminal count cancels the expiry.
  assign expire = run & ~restart & (count == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      if (restart) begin
        count <= '0;
      end else if (!expire) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// Memory-game sequencer: Moore control outputs, round/win/timeout tracking; GAME_CTRL_LIVES_EN adds lives and RETRY.
// Latency: outputs follow state register by 0 cycles. Backpressure: none; only enter rising edges advance button-driven states.
module game_controller
  import game_ctrl_pkg::*;
#(
  parameter int MAX_ROUNDS  = 16,
  parameter int ROUND_W     = 5,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int TIMER_W     = 26,
  parameter int LIVES       = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enter,
  input  logic               end_fpga,
  input  logic               end_user,
  input  logic               match,
  input  logic               user_act,
  output logic               r1,
  output logic               r2,
  output logic               e1,
  output logic               e2,
  output logic               e3,
  output logic               e4,
  output logic               sel,
  output logic [ROUND_W-1:0] round,
  output logic               win,
  output logic               timeout,
  output logic [ROUND_W-1:0] lives_left
);

  localparam logic [ROUND_W-1:0] ROUND_MAX = ROUND_W'(MAX_ROUNDS);

  state_t             state;
  state_t             next_state;
  logic [OUT_W-1:0]   outs;
  logic               enter_q;
  logic               enter_rise;
  logic               expire;
  logic               can_retry;
  logic               retry_go;
  logic               timer_clear;
  logic [ROUND_W-1:0] round_nxt;

  assign enter_rise = enter & ~enter_q;
  assign round_nxt  = (round == ROUND_MAX) ? round : round + 1'b1;

`ifdef GAME_CTRL_LIVES_EN
  logic [ROUND_W-1:0] lives_q;

  assign can_retry  = (lives_q > ROUND_W'(1));
  assign lives_left = lives_q;

  always_ff @(posedge clock) begin
    if (reset || state == S_INIT) begin
      lives_q <= ROUND_W'(LIVES);
    end else if (retry_go) begin
      lives_q <= lives_q - 1'b1;
    end
  end
`else
  // Single life: every failure ends the game.
  assign can_retry  = 1'b0;
  assign lives_left = ROUND_W'(LIVES > 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    outs       = '0;
    retry_go   = 1'b0;
    case (state)
      S_INIT: begin
        outs[O_R1] = 1'b1;
        outs[O_R2] = 1'b1;
        next_state = S_SETUP;
      end
      S_SETUP: begin
        outs[O_E1] = 1'b1;
        if (enter_rise) next_state = S_PLAY_FPGA;
      end
      S_PLAY_FPGA: begin
        outs[O_E3] = 1'b1;
        if (end_fpga) next_state = S_PLAY_USER;
      end
      S_PLAY_USER: begin
        outs[O_E2] = 1'b1;
        if (expire) begin
          retry_go   = can_retry;
          next_state = can_retry ? S_RETRY : S_RESULT;
        end else if (end_user) begin
          next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        outs[O_E4] = 1'b1;
        if (match) begin
          next_state = S_NEXT_ROUND;
        end else begin
          retry_go   = can_retry;
          next_state = can_retry ? S_RETRY : S_RESULT;
        end
      end
      S_NEXT_ROUND: begin
        outs[O_R2] = 1'b1;
        next_state = (round_nxt == ROUND_MAX) ? S_RESULT : S_PLAY_FPGA;
      end
      S_RESULT: begin
        outs[O_SEL] = 1'b1;
        if (enter_rise) next_state = S_INIT;
      end
`ifdef GAME_CTRL_LIVES_EN
      S_RETRY: begin
        outs[O_R2] = 1'b1;
        next_state = S_PLAY_FPGA;
      end
`endif
      default: next_state = S_INIT;
    endcase
  end

  assign r1  = outs[O_R1];
  assign r2  = outs[O_R2];
  assign e1  = outs[O_E1];
  assign e2  = outs[O_E2];
  assign e3  = outs[O_E3];
  assign e4  = outs[O_E4];
  assign sel = outs[O_SEL];

  always_ff @(posedge clock) begin
    if (reset) begin
      enter_q <= 1'b0;
      round   <= '0;
      win     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      enter_q <= enter;
      case (state)
        S_INIT: begin
          round   <= '0;
          win     <= 1'b0;
          timeout <= 1'b0;
        end
        S_PLAY_USER: begin
          if (expire) timeout <= ~can_retry;
        end
        S_NEXT_ROUND: begin
          round <= round_nxt;
          if (round_nxt == ROUND_MAX) win <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign timer_clear = (state == S_INIT) || (state == S_PLAY_FPGA && end_fpga) || retry_go;

  game_timer #(
    .TIMER_W    (TIMER_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .run    (state == S_PLAY_USER),
    .restart(user_act),
    .expire (expire)
  );

endmodule

// File: tb/tb_game_controller.sv
// Directed scoreboard bench for game_controller (MAX_ROUNDS=3, TIMEOUT_CYC=8, LIVES=2).
module tb_game_controller;

  logic       clock = 1'b0;
  logic       reset, enter, end_fpga, end_user, match, user_act;
  logic       r1, r2, e1, e2, e3, e4, sel, win, timeout;
  logic [4:0] round, lives_left;

  always #5 clock = ~clock;

  game_controller #(
    .MAX_ROUNDS(3), .ROUND_W(5), .TIMEOUT_CYC(8), .TIMER_W(4), .LIVES(2)
  ) dut (
    .clock(clock), .reset(reset), .enter(enter), .end_fpga(end_fpga),
    .end_user(end_user), .match(match), .user_act(user_act),
    .r1(r1), .r2(r2), .e1(e1), .e2(e2), .e3(e3), .e4(e4), .sel(sel),
    .round(round), .win(win), .timeout(timeout), .lives_left(lives_left)
  );

  // {r1,r2,e1,e2,e3,e4,sel} per state
  localparam logic [6:0] O_INIT   = 7'b1100000;
  localparam logic [6:0] O_SETUP  = 7'b0010000;
  localparam logic [6:0] O_FPGA   = 7'b0000100;
  localparam logic [6:0] O_USER   = 7'b0001000;
  localparam logic [6:0] O_CHECK  = 7'b0000010;
  localparam logic [6:0] O_NEXT   = 7'b0100000;
  localparam logic [6:0] O_RESULT = 7'b0000001;
`ifdef GAME_CTRL_LIVES_EN
  localparam logic [6:0] O_RETRY  = 7'b0100000;
  localparam int LV0 = 2;
`else
  localparam int LV0 = 1;
`endif
  localparam logic [18:0] ALL       = '1;
  localparam logic [18:0] OUTS_ONLY = {7'h7f, 12'h000};

  typedef struct {
    string       tag;
    logic [18:0] val;
    logic [18:0] mask;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   lv;

  wire [18:0] obs = {r1, r2, e1, e2, e3, e4, sel, round, win, timeout, lives_left};

  task automatic step(input string tag, input logic [6:0] o, input int rnd,
                      input logic w, input logic t, input logic [18:0] m = ALL);
    exp_t e;
    e.tag  = tag;
    e.val  = {o, 5'(rnd), w, t, 5'(lv)};
    e.mask = m;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    total++;
    assert ((obs & e.mask) === (e.val & e.mask))
      else begin
        bad++;
        $error("FAIL %s got=%b exp=%b", e.tag, obs & e.mask, e.val & e.mask);
      end
  endtask

  // From PLAY_FPGA at round r through to CHECK.
  task automatic play_to_check(input int r);
    end_fpga = 1'b1;
    step("to_user", O_USER, r, 1'b0, 1'b0);
    end_fpga = 1'b0;
    step("user_wait", O_USER, r, 1'b0, 1'b0);
    end_user = 1'b1;
    step("to_check", O_CHECK, r, 1'b0, 1'b0);
    end_user = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    {reset, enter, end_fpga, end_user, match, user_act} = '0;
    lv    = LV0;
    reset = 1'b1;
    step("reset", O_INIT, 0, 1'b0, 1'b0);
    step("reset_hold", O_INIT, 0, 1'b0, 1'b0);
    reset = 1'b0;
    step("init_to_setup", O_SETUP, 0, 1'b0, 1'b0);
    step("setup_idle", O_SETUP, 0, 1'b0, 1'b0);

    // Full win: three matched rounds.
    enter = 1'b1;
    step("enter_go", O_FPGA, 0, 1'b0, 1'b0);
    enter = 1'b0;
    for (int r = 0; r < 3; r++) begin
      play_to_check(r);
      match = 1'b1;
      step("next_round", O_NEXT, r, 1'b0, 1'b0);
      match = 1'b0;
      if (r < 2) step("next_fpga", O_FPGA, r + 1, 1'b0, 1'b0);
      else       step("win_result", O_RESULT, 3, 1'b1, 1'b0);
    end
    step("result_hold1", O_RESULT, 3, 1'b1, 1'b0);
    step("result_hold2", O_RESULT, 3, 1'b1, 1'b0);
    enter = 1'b1;
    step("result_to_init", O_INIT, 3, 1'b1, 1'b0, OUTS_ONLY);
    step("init_cleared", O_SETUP, 0, 1'b0, 1'b0);
    step("held_enter_setup", O_SETUP, 0, 1'b0, 1'b0);
    enter = 1'b0;
    step("setup_release", O_SETUP, 0, 1'b0, 1'b0);

    // Mismatch in round 0.
    enter = 1'b1;
    step("enter_go2", O_FPGA, 0, 1'b0, 1'b0);
    enter = 1'b0;
    play_to_check(0);
`ifdef GAME_CTRL_LIVES_EN
    lv = 1;
    step("miss_retry", O_RETRY, 0, 1'b0, 1'b0);
    step("retry_fpga", O_FPGA, 0, 1'b0, 1'b0);
    play_to_check(0);
    step("miss_final", O_RESULT, 0, 1'b0, 1'b0);
`else
    step("miss_result", O_RESULT, 0, 1'b0, 1'b0);
`endif
    enter = 1'b1;
    step("miss_to_init", O_INIT, 0, 1'b0, 1'b0, OUTS_ONLY);
    enter = 1'b0;
    lv    = LV0;
    step("setup3", O_SETUP, 0, 1'b0, 1'b0);

    // Timeout in round 1, with one user_act restarting the timer.
    enter = 1'b1;
    step("enter_go3", O_FPGA, 0, 1'b0, 1'b0);
    enter = 1'b0;
    play_to_check(0);
    match = 1'b1;
    step("next_round3", O_NEXT, 0, 1'b0, 1'b0);
    match = 1'b0;
    step("fpga_r1", O_FPGA, 1, 1'b0, 1'b0);
    end_fpga = 1'b1;
    step("user_r1", O_USER, 1, 1'b0, 1'b0);
    end_fpga = 1'b0;
    for (int i = 0; i < 5; i++) step("idle_a", O_USER, 1, 1'b0, 1'b0);
    user_act = 1'b1;
    step("user_act", O_USER, 1, 1'b0, 1'b0);
    user_act = 1'b0;
    for (int i = 0; i < 7; i++) step("idle_b", O_USER, 1, 1'b0, 1'b0);
`ifdef GAME_CTRL_LIVES_EN
    lv = 1;
    step("expire_retry", O_RETRY, 1, 1'b0, 1'b0);
    step("retry_fpga_r1", O_FPGA, 1, 1'b0, 1'b0);
`else
    step("timeout_result", O_RESULT, 1, 1'b0, 1'b1);
    step("timeout_hold", O_RESULT, 1, 1'b0, 1'b1);
`endif

    // Expiry coinciding with end_user.
    reset = 1'b1;
    lv    = LV0;
    step("reset_mid", O_INIT, 0, 1'b0, 1'b0);
    reset = 1'b0;
    step("setup4", O_SETUP, 0, 1'b0, 1'b0);
    enter = 1'b1;
    step("enter_go4", O_FPGA, 0, 1'b0, 1'b0);
    enter    = 1'b0;
    end_fpga = 1'b1;
    step("user_r0", O_USER, 0, 1'b0, 1'b0);
    end_fpga = 1'b0;
    for (int i = 0; i < 7; i++) step("idle_c", O_USER, 0, 1'b0, 1'b0);
    end_user = 1'b1;
`ifdef GAME_CTRL_LIVES_EN
    lv = 1;
    step("expiry_wins", O_RETRY, 0, 1'b0, 1'b0);
    end_user = 1'b0;
    step("no_check", O_FPGA, 0, 1'b0, 1'b0);
`else
    step("expiry_wins", O_RESULT, 0, 1'b0, 1'b1);
    end_user = 1'b0;
    step("no_check", O_RESULT, 0, 1'b0, 1'b1);
`endif

    // Held enter stops in PLAY_FPGA; reset from PLAY_USER at round 2.
    reset = 1'b1;
    lv    = LV0;
    step("reset5", O_INIT, 0, 1'b0, 1'b0);
    reset = 1'b0;
    step("setup5", O_SETUP, 0, 1'b0, 1'b0);
    enter = 1'b1;
    for (int i = 0; i < 20; i++) step("held_enter", O_FPGA, 0, 1'b0, 1'b0);
    enter = 1'b0;
    for (int r = 0; r < 2; r++) begin
      play_to_check(r);
      match = 1'b1;
      step("next_round5", O_NEXT, r, 1'b0, 1'b0);
      match = 1'b0;
      step("fpga5", O_FPGA, r + 1, 1'b0, 1'b0);
    end
    end_fpga = 1'b1;
    step("user_r2", O_USER, 2, 1'b0, 1'b0);
    end_fpga = 1'b0;
    reset    = 1'b1;
    step("reset_in_user", O_INIT, 0, 1'b0, 1'b0);
    reset = 1'b0;
    step("setup_after_reset", O_SETUP, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
